// File: rtl/mem_pkg.sv
// Shared command encoding and FSM state type for the two-master RAM arbiter.
package mem_pkg;

    typedef logic [1:0] mem_cmd_t;

    localparam mem_cmd_t MNONE  = 2'b00;
    localparam mem_cmd_t MREAD  = 2'b01;
    localparam mem_cmd_t MWRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        ACK
    } arb_state_t;

    // Code 2'b11 is reserved and behaves exactly like MNONE.
    function automatic logic cmd_valid(input mem_cmd_t cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between m0 and m1; one transaction at a time,
// sequenced IDLE -> ACCESS -> (WAIT for reads) -> ACK.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW     = 9,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  mem_cmd_t      m0_cmd,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  mem_cmd_t      m1_cmd,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_write,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          owner,
    output arb_state_t    fsm_state
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    arb_state_t    state;
    arb_state_t    next_state;
    mem_cmd_t      lat_cmd;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          last;
    logic [2:0]    lat_cnt;
    logic [1:0]    req;
    logic          winner;

    assign req = {cmd_valid(m1_cmd), cmd_valid(m0_cmd)};

    rr_arb2 u_arb (
        .req    (req),
        .last   (last),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req != 2'b00) next_state = ACCESS;
            ACCESS:  next_state = (lat_cmd == MWRITE) ? ACK : WAIT;
            WAIT:    if (lat_cnt == 3'd1) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured once in IDLE; later input changes cannot disturb the access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cmd   <= MNONE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            owner     <= 1'b0;
            last      <= 1'b1;
            lat_cnt   <= 3'd0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner     <= winner;
                        last      <= winner;
                        lat_cmd   <= winner ? m1_cmd : m0_cmd;
                        lat_addr  <= winner ? m1_addr : m0_addr;
                        lat_wdata <= winner ? m1_wdata : m0_wdata;
                    end
                end
                ACCESS: begin
                    if (lat_cmd == MREAD) lat_cnt <= LAT_INIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        if (owner) m1_rdata <= ram_rdata;
                        else       m0_rdata <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_write = (state == ACCESS) && (lat_cmd == MWRITE);
        m0_ack    = (state == ACK) && !owner;
        m1_ack    = (state == ACK) && owner;
        busy      = (state != IDLE);
    end

    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    assign fsm_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RD_LAT=1 instance with a plain RAM model and a
// RD_LAT=3 instance whose RAM output changes every cycle to pin down the capture cycle.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    mem_cmd_t      m0_cmd, m1_cmd;
    logic [AW-1:0] m0_addr, m1_addr, ram_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_wdata, ram_rdata;
    logic          m0_ack, m1_ack, ram_write, busy, owner;
    arb_state_t    fsm_state;

    mem_cmd_t      b_m0_cmd, b_m1_cmd;
    logic [AW-1:0] b_m0_addr, b_m1_addr, b_ram_addr;
    logic [DW-1:0] b_m0_wdata, b_m1_wdata, b_m0_rdata, b_m1_rdata, b_ram_wdata, b_ram_rdata;
    logic          b_m0_ack, b_m1_ack, b_ram_write, b_busy, b_owner;
    arb_state_t    b_fsm_state;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write), .ram_rdata(ram_rdata),
        .busy(busy), .owner(owner), .fsm_state(fsm_state)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .m0_cmd(b_m0_cmd), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_cmd(b_m1_cmd), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_write(b_ram_write), .ram_rdata(b_ram_rdata),
        .busy(b_busy), .owner(b_owner), .fsm_state(b_fsm_state)
    );

    function automatic logic [DW-1:0] init_a(input int i);
        return 16'(i * 3 + 263);
    endfunction

    function automatic logic [DW-1:0] init_b(input int i);
        return 16'(i * 7 + 100);
    endfunction

    // RAM models: A has one cycle of latency; B has three, and adds the cycle count so a
    // capture one cycle early or late reads a different value.
    logic [DW-1:0] mem_a [512];
    logic [DW-1:0] mem_b [512];
    logic [DW-1:0] pipe_b [3];
    logic [15:0]   cyc = 16'd0;
    logic          ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 512; i++) begin
                mem_a[i] <= init_a(i);
                mem_b[i] <= init_b(i);
            end
            ram_ready <= 1'b1;
        end else begin
            if (ram_write) mem_a[ram_addr] <= ram_wdata;
            if (b_ram_write) mem_b[b_ram_addr] <= b_ram_wdata;
        end
        ram_rdata <= mem_a[ram_addr];
        pipe_b[0] <= mem_b[b_ram_addr] + cyc;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        cyc <= cyc + 16'd1;
    end

    assign b_ram_rdata = pipe_b[2];

    // Scoreboard for instance A: {owner, rdata} expected at each ack, in grant order.
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] model_a [512];
    logic [DW-1:0] exp_rd0, exp_rd1;
    logic          tb_last;

    always @(negedge clk) begin
        logic [DW:0] got;
        logic [DW:0] exp;
        if (!reset && (m0_ack || m1_ack)) begin
            got = {m1_ack, m1_ack ? m1_rdata : m0_rdata};
            vectors++;
            if (m0_ack && m1_ack) begin
                miscompares++;
                $display("FAIL sb_dual_ack: got m0_ack=1 m1_ack=1, required one ack");
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_ack: got owner/rdata %h, required no ack", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL sb_ack_data: got owner/rdata %h, required %h", got, exp);
                end
            end
        end
    end

    task automatic push_exp(input logic m, input mem_cmd_t cmd, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
        if (cmd == MWRITE) begin
            model_a[addr] = wdata;
            exp_q.push_back({m, m ? exp_rd1 : exp_rd0});
        end else begin
            if (m) exp_rd1 = model_a[addr];
            else   exp_rd0 = model_a[addr];
            exp_q.push_back({m, model_a[addr]});
        end
        tb_last = m;
    endtask

    // Called at posedge+1 with the DUT idle; that cycle is cycle 0.
    task automatic run_txn(input logic m, input mem_cmd_t cmd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output int lat, output int wr_n,
                           output int wr_cyc, output logic [AW-1:0] wr_addr,
                           output logic [DW-1:0] wr_data);
        push_exp(m, cmd, addr, wdata);
        if (m) begin m1_cmd = cmd; m1_addr = addr; m1_wdata = wdata; end
        else   begin m0_cmd = cmd; m0_addr = addr; m0_wdata = wdata; end
        lat = -1; wr_n = 0; wr_cyc = -1; wr_addr = '0; wr_data = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ram_write) begin
                wr_n++; wr_cyc = k; wr_addr = ram_addr; wr_data = ram_wdata;
            end
            if (m ? m1_ack : m0_ack) begin
                lat = k;
                break;
            end
        end
        @(posedge clk); #1;
        if (m) m1_cmd = MNONE; else m0_cmd = MNONE;
        if (lat < 0) begin
            vectors++; miscompares++;
            $display("FAIL txn_timeout: got no ack in 20 cycles, required ack from m%0d", m);
        end
    endtask

    task automatic test_reset();
        int lat;
        m0_cmd = MREAD; m0_addr = 9'h003; m0_wdata = '0;
        m1_cmd = MREAD; m1_addr = 9'h004; m1_wdata = '0;
        b_m0_cmd = MREAD; b_m0_addr = 9'h007; b_m0_wdata = '0;
        b_m1_cmd = MNONE; b_m1_addr = '0; b_m1_wdata = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, ram_write, m0_ack, m1_ack, owner, ram_addr, ram_wdata, m0_rdata, m1_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs_a: got busy=%b wr=%b ack=%b%b owner=%b addr=%h wd=%h rd0=%h rd1=%h, required all 0",
                     busy, ram_write, m0_ack, m1_ack, owner, ram_addr, ram_wdata, m0_rdata, m1_rdata);
        end
        vectors++;
        if ({b_busy, b_ram_write, b_m0_ack, b_m1_ack, b_owner, b_ram_addr, b_ram_wdata, b_m0_rdata, b_m1_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs_b: got busy=%b wr=%b owner=%b addr=%h, required all 0",
                     b_busy, b_ram_write, b_owner, b_ram_addr);
        end
        vectors++;
        if (fsm_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d, required IDLE", fsm_state);
        end
        @(posedge clk); #1;
        b_m0_cmd = MNONE;
        reset = 1'b0;
        push_exp(1'b0, MREAD, 9'h003, '0);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                vectors++;
                if ({busy, owner} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL first_grant: got busy=%b owner=%b, required busy=1 owner=0", busy, owner);
                end
            end
            if (m0_ack) begin
                lat = k;
                break;
            end
        end
        @(posedge clk); #1;
        m0_cmd = MNONE; m1_cmd = MNONE;
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL first_read_latency: got %0d, required 3", lat);
        end
    endtask

    task automatic test_write_read();
        int lat, wr_n, wr_cyc;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        run_txn(1'b0, MWRITE, 9'h005, 16'hBEEF, lat, wr_n, wr_cyc, wa, wd);
        vectors++;
        if ({wr_n, wr_cyc, lat} !== {32'd1, 32'd1, 32'd2}) begin
            miscompares++;
            $display("FAIL write_timing: got writes=%0d wr_cycle=%0d ack_cycle=%0d, required 1/1/2", wr_n, wr_cyc, lat);
        end
        vectors++;
        if ({wa, wd} !== {9'h005, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL write_bus: got addr=%h data=%h, required 005/beef", wa, wd);
        end
        run_txn(1'b0, MREAD, 9'h005, 16'h0000, lat, wr_n, wr_cyc, wa, wd);
        vectors++;
        if ({wr_n, lat} !== {32'd0, 32'd3}) begin
            miscompares++;
            $display("FAIL read_timing: got writes=%0d ack_cycle=%0d, required 0/3", wr_n, lat);
        end
        vectors++;
        if (m0_rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL read_back: got %h, required beef", m0_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic first, o, a0, a1;
        int n0, n1, n, last_k;
        first = ~tb_last;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 4; k++) begin
            o = first ^ k[0];
            if (o) begin push_exp(1'b1, MREAD, 9'(32'h020 + n1), '0); n1++; end
            else   begin push_exp(1'b0, MREAD, 9'(32'h010 + n0), '0); n0++; end
        end
        m0_cmd = MREAD; m0_addr = 9'h010;
        m1_cmd = MREAD; m1_addr = 9'h020;
        n = 0; last_k = -1;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            a0 = m0_ack; a1 = m1_ack;
            if (a0 || a1) begin n++; last_k = k; end
            @(posedge clk); #1;
            if (n == 4) begin
                m0_cmd = MNONE; m1_cmd = MNONE;
            end else begin
                if (a0) m0_addr = m0_addr + 9'd1;
                if (a1) m1_addr = m1_addr + 9'd1;
            end
        end
        m0_cmd = MNONE; m1_cmd = MNONE;
        vectors++;
        if ({n, last_k} !== {32'd4, 32'd15}) begin
            miscompares++;
            $display("FAIL rr_throughput: got acks=%0d last_ack_cycle=%0d, required 4/15", n, last_k);
        end
        vectors++;
        if ({m0_rdata, m1_rdata} !== {exp_rd0, exp_rd1}) begin
            miscompares++;
            $display("FAIL rr_rdata: got %h/%h, required %h/%h", m0_rdata, m1_rdata, exp_rd0, exp_rd1);
        end
    endtask

    task automatic test_latched_cmd();
        int lat, lat0, lat1, wr_n, wr_cyc;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        run_txn(1'b1, MREAD, 9'h1FF, '0, lat, wr_n, wr_cyc, wa, wd);
        push_exp(1'b0, MWRITE, 9'h030, 16'hA5A5);
        push_exp(1'b1, MWRITE, 9'h1FF, 16'h1234);
        m0_cmd = MWRITE; m0_addr = 9'h030; m0_wdata = 16'hA5A5;
        m1_cmd = MWRITE; m1_addr = 9'h1FF; m1_wdata = 16'h1234;
        lat0 = -1; lat1 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m0_ack) lat0 = k;
            if (m1_ack) lat1 = k;
            @(posedge clk); #1;
            if (k == 0) begin
                m0_cmd = MNONE; m0_addr = 9'h031; m0_wdata = 16'hFFFF;
            end
            if (lat1 >= 0) break;
        end
        m1_cmd = MNONE;
        vectors++;
        if ({lat0, lat1} !== {32'd2, 32'd5}) begin
            miscompares++;
            $display("FAIL latched_ack_cycles: got m0=%0d m1=%0d, required 2/5", lat0, lat1);
        end
        run_txn(1'b0, MREAD, 9'h030, '0, lat, wr_n, wr_cyc, wa, wd);
        vectors++;
        if (m0_rdata !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL latched_m0_data: got %h, required a5a5", m0_rdata);
        end
        run_txn(1'b1, MREAD, 9'h1FF, '0, lat, wr_n, wr_cyc, wa, wd);
        vectors++;
        if (m1_rdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL latched_m1_data: got %h, required 1234", m1_rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        logic found;
        found = 1'b0;
        m1_cmd = MREAD; m1_addr = 9'h044;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fsm_state == WAIT) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL wait_reached: got no WAIT state in 10 cycles, required WAIT");
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({fsm_state, busy, ram_write, m1_ack} !== {IDLE, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_abort_state: got state=%0d busy=%b wr=%b ack=%b, required IDLE/0/0/0",
                     fsm_state, busy, ram_write, m1_ack);
        end
        vectors++;
        if ({m0_rdata, m1_rdata, ram_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_abort_regs: got rd0=%h rd1=%h addr=%h, required 0", m0_rdata, m1_rdata, ram_addr);
        end
        m1_cmd = MNONE;
        exp_rd0 = '0; exp_rd1 = '0; tb_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, m1_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_abort_after: got busy=%b rd1=%h, required 0/0", busy, m1_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rdlat3();
        logic [15:0]   c0;
        logic [DW-1:0] exp;
        int lat, nwait;
        m0_cmd = 2'b11; m1_cmd = 2'b11; b_m0_cmd = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if ({busy, b_busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL cmd11_ignored: got busy=%b b_busy=%b, required 0/0", busy, b_busy);
            end
        end
        @(posedge clk); #1;
        m0_cmd = MNONE; m1_cmd = MNONE;
        c0 = cyc;
        exp = init_b(32'h040) + c0 + 16'd1;
        b_m0_cmd = MREAD; b_m0_addr = 9'h040;
        lat = -1; nwait = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b_fsm_state == WAIT) nwait++;
            if (b_m1_ack) begin
                vectors++; miscompares++;
                $display("FAIL rdlat3_wrong_ack: got b_m1_ack=1, required 0");
            end
            if (b_m0_ack) begin
                lat = k;
                break;
            end
        end
        @(posedge clk); #1;
        b_m0_cmd = MNONE;
        vectors++;
        if ({lat, nwait} !== {32'd5, 32'd3}) begin
            miscompares++;
            $display("FAIL rdlat3_timing: got ack_cycle=%0d wait_cycles=%0d, required 5/3", lat, nwait);
        end
        vectors++;
        if (b_m0_rdata !== exp) begin
            miscompares++;
            $display("FAIL rdlat3_data: got %h, required %h", b_m0_rdata, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) model_a[i] = init_a(i);
        exp_rd0 = '0; exp_rd1 = '0; tb_last = 1'b1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_latched_cmd();
        test_reset_in_wait();
        test_rdlat3();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending acks, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
